// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM-port signal bundle for bram_port_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the BRAM.
interface bram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, douta,
    input  wr_gnt, rd_gnt, rd_valid, rd_data, ena, wea, addra, dina
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, douta,
    output wr_gnt, rd_gnt, rd_valid, rd_data, ena, wea, addra, dina
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-requester (write / read) arbiter in front of a single BRAM port.
// Default is round-robin; define ARB_WR_PRIORITY_EN for write priority with read anti-starvation.
module bram_port_arbiter #(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  bram_port_arbiter_if.slave bus
);

  logic wr_win;
  logic wr_gnt;
  logic rd_gnt;

`ifdef ARB_WR_PRIORITY_EN
  // Consecutive write grants taken while a read was waiting.
  logic [2:0] starve_q;
  logic [2:0] starve_d;

  assign wr_win = (starve_q < 3'd4);

  always_comb begin
    starve_d = starve_q;
    if (rd_gnt || !bus.rd_req) begin
      starve_d = 3'd0;
    end else if (wr_gnt) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic last_wr;

  assign wr_win = ~last_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_wr <= 1'b0;
    end else if (wr_gnt) begin
      last_wr <= 1'b1;
    end else if (rd_gnt) begin
      last_wr <= 1'b0;
    end
  end
`endif

  // Grants are gated by rst so they read 0 throughout reset.
  assign wr_gnt = rst & bus.wr_req & (~bus.rd_req | wr_win);
  assign rd_gnt = rst & bus.rd_req & (~bus.wr_req | ~wr_win);

  logic              ena_q;
  logic              wea_q;
  logic [ADDR_W-1:0] addra_q;
  logic [DATA_W-1:0] dina_q;
  logic [READ_LAT:0] vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      vld_q   <= '0;
    end else begin
      ena_q <= wr_gnt | rd_gnt;
      wea_q <= wr_gnt;
      if (wr_gnt) begin
        addra_q <= bus.wr_addr;
        dina_q  <= bus.wr_data;
      end else if (rd_gnt) begin
        addra_q <= bus.rd_addr;
      end
      // Bit k is set k+1 cycles after a read grant; the top bit lines up with douta.
      vld_q <= {vld_q[READ_LAT-1:0], rd_gnt};
    end
  end

  assign bus.wr_gnt   = wr_gnt;
  assign bus.rd_gnt   = rd_gnt;
  assign bus.ena      = ena_q;
  assign bus.wea      = wea_q;
  assign bus.addra    = addra_q;
  assign bus.dina     = dina_q;
  assign bus.rd_valid = vld_q[READ_LAT];
  assign bus.rd_data  = bus.douta;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: READ_LAT=1 and READ_LAT=2 instances share one stimulus.
// Read data is checked against a shadow memory through a per-instance expectation queue.
`timescale 1ns/1ps
module tb_bram_port_arbiter;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;

  bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
  bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

  bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus1.wr_req  = wr_req;
  assign bus1.wr_addr = wr_addr;
  assign bus1.wr_data = wr_data;
  assign bus1.rd_req  = rd_req;
  assign bus1.rd_addr = rd_addr;
  assign bus2.wr_req  = wr_req;
  assign bus2.wr_addr = wr_addr;
  assign bus2.wr_data = wr_data;
  assign bus2.rd_req  = rd_req;
  assign bus2.rd_addr = rd_addr;

  // BRAM models: one-cycle read for bus1, two-cycle read for bus2.
  logic [DATA_W-1:0] mem1 [0:DEPTH-1];
  logic [DATA_W-1:0] mem2 [0:DEPTH-1];
  logic [DATA_W-1:0] dq1, dq2a, dq2b;
  always @(posedge clk) begin
    if (bus1.ena) begin
      if (bus1.wea) mem1[bus1.addra] <= bus1.dina;
      else          dq1 <= mem1[bus1.addra];
    end
    if (bus2.ena) begin
      if (bus2.wea) mem2[bus2.addra] <= bus2.dina;
      else          dq2a <= mem2[bus2.addra];
    end
    dq2b <= dq2a;
  end
  assign bus1.douta = dq1;
  assign bus2.douta = dq2b;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectations pushed at read acceptance, popped on rd_valid.
  logic [DATA_W-1:0] shadow [0:DEPTH-1];
  exp_t q1[$];
  exp_t q2[$];
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus1.wr_gnt) shadow[wr_addr] = wr_data;
      if (bus1.rd_gnt) begin
        e.data = shadow[rd_addr];
        e.cyc  = cyc + 2;
        q1.push_back(e);
      end
      if (bus2.rd_gnt) begin
        e.data = shadow[rd_addr];
        e.cyc  = cyc + 3;
        q2.push_back(e);
      end
      if (bus1.rd_valid) begin
        if (q1.size() == 0) check("rd1_spurious", 32'(bus1.rd_valid), 32'd0);
        else begin
          e = q1.pop_front();
          check("rd1_data", 32'(bus1.rd_data), 32'(e.data));
          check("rd1_cycle", cyc, e.cyc);
        end
      end
      if (bus2.rd_valid) begin
        if (q2.size() == 0) check("rd2_spurious", 32'(bus2.rd_valid), 32'd0);
        else begin
          e = q2.pop_front();
          check("rd2_data", 32'(bus2.rd_data), 32'(e.data));
          check("rd2_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check_port(input string tag, input logic e_ena, input logic e_wea,
                            input logic [ADDR_W-1:0] e_addr, input logic [DATA_W-1:0] e_din);
    check({tag, "_ena"}, 32'(bus1.ena), 32'(e_ena));
    check({tag, "_wea"}, 32'(bus1.wea), 32'(e_wea));
    check({tag, "_addra"}, 32'(bus1.addra), 32'(e_addr));
    check({tag, "_dina"}, 32'(bus1.dina), 32'(e_din));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ena1"}, 32'(bus1.ena), 32'd0);
    check({tag, "_wea1"}, 32'(bus1.wea), 32'd0);
    check({tag, "_addra1"}, 32'(bus1.addra), 32'd0);
    check({tag, "_dina1"}, 32'(bus1.dina), 32'd0);
    check({tag, "_rdv1"}, 32'(bus1.rd_valid), 32'd0);
    check({tag, "_wgnt1"}, 32'(bus1.wr_gnt), 32'd0);
    check({tag, "_rgnt1"}, 32'(bus1.rd_gnt), 32'd0);
    check({tag, "_ena2"}, 32'(bus2.ena), 32'd0);
    check({tag, "_rdv2"}, 32'(bus2.rd_valid), 32'd0);
    check({tag, "_rgnt2"}, 32'(bus2.rd_gnt), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(q1.size() + q2.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_w;
`ifdef ARB_WR_PRIORITY_EN
    exp_w = 6'b101111;  // W,W,W,W,R,W (bit i = write expected in cycle i)
`else
    exp_w = 6'b010101;  // W,R,W,R,W,R
`endif
    // Reset with both requests raised: everything must read 0.
    rst = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    mid();
    check_all_zero("reset");

    // Write only, in the first cycle out of reset.
    tick();
    rst = 1'b1; rd_req = 1'b0;
    wr_addr = 13'h005; wr_data = 8'h3C;
    mid();
    check("wo_wr_gnt", 32'(bus1.wr_gnt), 32'd1);
    check("wo_rd_gnt", 32'(bus1.rd_gnt), 32'd0);
    tick();
    wr_req = 1'b0;
    mid();
    check_port("wo_port", 1'b1, 1'b1, 13'h005, 8'h3C);
    tick();
    mid();
    check_port("idle_port", 1'b0, 1'b0, 13'h005, 8'h3C);

    // Read-after-write to the top address.
    tick();
    wr_req = 1'b1; wr_addr = 13'h1FFF; wr_data = 8'hA7;
    mid();
    check("raw_wr_gnt", 32'(bus1.wr_gnt), 32'd1);
    tick();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 13'h1FFF;
    mid();
    check("raw_rd_gnt", 32'(bus1.rd_gnt), 32'd1);
    check("raw_wr_gnt_off", 32'(bus1.wr_gnt), 32'd0);
    check_port("raw_wport", 1'b1, 1'b1, 13'h1FFF, 8'hA7);
    tick();
    rd_req = 1'b0;
    mid();
    check_port("raw_rport", 1'b1, 1'b0, 13'h1FFF, 8'hA7);
    drain();

    // Streaming: fill 0..7, then read them back every cycle.
    tick();
    wr_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_addr = 13'(i);
      wr_data = 8'(8'h10 + i);
      mid();
      check("str_wr_gnt", 32'(bus1.wr_gnt), 32'd1);
      tick();
    end
    wr_req = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 13'(i);
      mid();
      check("str_rd_gnt", 32'(bus1.rd_gnt), 32'd1);
      tick();
    end
    rd_req = 1'b0;
    drain();

    // Reset one cycle after the second of two reads: no pulses may survive.
    tick();
    rd_req = 1'b1; rd_addr = 13'h000;
    mid();
    check("rmr_gnt0", 32'(bus2.rd_gnt), 32'd1);
    tick();
    rd_addr = 13'h001;
    mid();
    check("rmr_gnt1", 32'(bus2.rd_gnt), 32'd1);
    tick();
    rst = 1'b0;
    q1.delete();
    q2.delete();
    mid();
    check_all_zero("rmr_reset");
    tick();
    rst = 1'b1; rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      check("rmr_rdv1", 32'(bus1.rd_valid), 32'd0);
      check("rmr_rdv2", 32'(bus2.rd_valid), 32'd0);
      tick();
    end

    // Contention with both requests held, state fresh from reset.
    wr_req = 1'b1; wr_addr = 13'h100; wr_data = 8'h5A;
    rd_req = 1'b1; rd_addr = 13'h005;
    for (int i = 0; i < 6; i++) begin
      mid();
      check("ctn_wr_gnt", 32'(bus1.wr_gnt), 32'(exp_w[i]));
      check("ctn_rd_gnt", 32'(bus1.rd_gnt), 32'(!exp_w[i]));
      if (i > 0) check("ctn_ena", 32'(bus1.ena), 32'd1);
      tick();
    end
    wr_req = 1'b0; rd_req = 1'b0;
    mid();
    check("ctn_ena_last", 32'(bus1.ena), 32'd1);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, BRAM address width.
REQ-002 Parameter DATA_W, default 8, BRAM data width.
REQ-003 Parameter READ_LAT, default 1, BRAM read latency in cycles; legal values are 1 and 2.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 wr_req  in  1  write requester (entry controller) request; held with wr_addr and wr_data stable until granted.
REQ-007 wr_addr  in  ADDR_W  write address.
REQ-008 wr_data  in  DATA_W  write data.
REQ-009 wr_gnt  out  1  combinational grant; the write is accepted at the rising edge where wr_req and wr_gnt are both 1.
REQ-010 rd_req  in  1  read requester (operand fetch/display) request; held with rd_addr stable until granted.
REQ-011 rd_addr  in  ADDR_W  read address.
REQ-012 rd_gnt  out  1  combinational grant for the read; same acceptance rule as wr_gnt.
REQ-013 rd_valid  out  1  one-cycle pulse marking rd_data valid.
REQ-014 rd_data  out  DATA_W  read data; equals douta while rd_valid is 1.
REQ-015 ena, wea  out  1 each  BRAM port enable and write enable, both registered.
REQ-016 addra  out  ADDR_W  BRAM address, registered.
REQ-017 dina  out  DATA_W  BRAM write data, registered.
REQ-018 douta  in  DATA_W  BRAM read data.

Function
REQ-019 At most one of wr_gnt and rd_gnt SHALL be 1 in any cycle; a grant SHALL be 1 only while its own request is 1.
REQ-020 Only one requester active: that requester SHALL be granted in the same cycle, giving back-to-back grants every cycle.
REQ-021 Both requesters active, default build: round-robin; grant the requester not granted last, tracked in register last_wr.
REQ-022 last_wr SHALL update only on an accepted grant: 1 after a write, 0 after a read.
REQ-023 Accepted write in cycle N: in cycle N+1, ena=1, wea=1, addra=wr_addr, dina=wr_data.
REQ-024 Accepted read in cycle N: in cycle N+1, ena=1, wea=0, addra=rd_addr; dina holds its previous value.
REQ-025 No grant in cycle N: ena=0 and wea=0 in cycle N+1; addra and dina hold their values.
REQ-026 Read granted in cycle N: rd_valid=1 and rd_data=douta in cycle N+1+READ_LAT; tracked by a READ_LAT+1 deep valid shift register.
REQ-027 Reads return strictly in issue order; back-to-back reads give back-to-back rd_valid pulses.
REQ-028 Write then read to the same address in consecutive grants: the read returns the new data (the BRAM port serialises them; the block adds no forwarding).
REQ-029 Requests dropped without a grant SHALL be ignored and SHALL NOT change state.

Reset
REQ-030 While rst=0: ena=0, wea=0, addra=0, dina=0, rd_valid=0, wr_gnt=0, rd_gnt=0, last_wr=0 (the write requester wins the first contention), and the valid pipeline is cleared.
REQ-031 Reset asserted with reads in flight: their rd_valid pulses SHALL never appear, including after rst returns to 1.
REQ-032 First grant possible in the first cycle with rst=1.

Configuration
REQ-033 Macro ARB_WR_PRIORITY_EN defined: under contention the write wins, except that after 4 consecutive write grants with rd_req continuously 1, the next contention cycle grants the read (starvation counter, 3 bits, cleared on any read grant or when rd_req=0).
REQ-034 Macro ARB_WR_PRIORITY_EN undefined: pure round-robin per REQ-021, and no starvation counter is built.

Verification
REQ-035 Write only: wr_req=1, wr_addr=0x005, wr_data=0x3C -> wr_gnt=1 that cycle; next cycle ena=1, wea=1, addra=0x005, dina=0x3C.
REQ-036 Read-after-write: write 0xA7 to 0x1FFF, then read 0x1FFF with READ_LAT=1 -> rd_valid pulses 2 cycles after rd_gnt with rd_data=0xA7.
REQ-037 Contention, default build: both requests held for 4 cycles after reset -> grants W,R,W,R; ena=1 every cycle.
REQ-038 Contention, ARB_WR_PRIORITY_EN defined: both requests held for 6 cycles -> grants W,W,W,W,R,W.
REQ-039 Reset mid-read: issue 2 reads with READ_LAT=2, then assert rst for 1 cycle in the cycle after the second grant -> no rd_valid pulse; all outputs 0 during reset.
REQ-040 Streaming: 8 consecutive reads to addresses 0..7 holding data 0x10..0x17 -> 8 consecutive rd_valid pulses returning data 0x10..0x17 in order.
